// File: rtl/mod47_pkg.sv
// Shared types and the mod-47 constant-multiply reference function for the
// mod47_scale_sched slice.
package mod47_pkg;

  localparam int MOD = 47;
  localparam int W   = 6;

  typedef logic [5:0] residue_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic residue_t mulc_mod(input residue_t x, input residue_t c);
    logic [11:0] prod;
    prod = 12'(x) * 12'(c);
    return residue_t'(prod % 12'(MOD));
  endfunction

endpackage

// File: rtl/mod47_scale_sched_if.sv
// Request/response bundle between residue producers, mod47_scale_sched and
// the downstream modular datapath.
interface mod47_scale_sched_if #(
  parameter int NREQ = 2,
  parameter int W    = 6,
  parameter int KW   = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*W-1:0]  req_x;
  logic [NREQ*KW-1:0] req_k;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [W-1:0]       rsp_y;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_err;

  modport master (
    output req_valid, req_x, req_k, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_x, req_k, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id, rsp_err
  );

endinterface

// File: rtl/mod47_mulc_lut.sv
// Combinational y = x*CONST mod 47 table; input must be a legal residue.
module mod47_mulc_lut
  import mod47_pkg::*;
#(
  parameter int CONST = 9
) (
  input  residue_t x,
  output residue_t y
);

  assign y = mulc_mod(x, residue_t'(CONST));

endmodule

// File: rtl/mod47_scale_sched.sv
// Round-robin sequencer sharing one mod-47 multiply LUT; each job runs k passes.
// Optional completed-response counter: define MOD47_SCALE_SCHED_STATS_EN.
module mod47_scale_sched #(
  parameter int W     = 6,
  parameter int MOD   = 47,
  parameter int CONST = 9,
  parameter int KW    = 4,
  parameter int NREQ  = 2
) (
  input  logic               clk,
  input  logic               rst,
  mod47_scale_sched_if.slave bus
`ifdef MOD47_SCALE_SCHED_STATS_EN
  ,
  output logic [15:0]        op_count
`endif
);
  import mod47_pkg::*;

  localparam int IDW = $clog2(NREQ);

  state_t          state_r, state_nx_s;
  residue_t        acc_r, lut_y_s;
  logic [KW-1:0]   cnt_r;
  logic [IDW-1:0]  id_r, rr_ptr_r, gnt_id_s;
  logic            err_r;
  logic            rsp_valid_r, rsp_err_r;
  logic [W-1:0]    rsp_y_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [NREQ-1:0] grant_s;
  logic            found_s, accept_s, rsp_fire_s, bad_x_s;
  int              idx_s;
  logic [W-1:0]    sel_x_s;
  logic [KW-1:0]   sel_k_s;

  mod47_mulc_lut #(.CONST(CONST)) u_lut (.x(acc_r), .y(lut_y_s));

  // Round-robin grant search starting at rr_ptr, only while idle.
  always_comb begin
    grant_s  = '0;
    gnt_id_s = '0;
    found_s  = 1'b0;
    idx_s    = 0;
    if (state_r == IDLE) begin
      for (int i = 0; i < NREQ; i++) begin
        idx_s = (int'(rr_ptr_r) + i) % NREQ;
        if (!found_s && bus.req_valid[idx_s]) begin
          found_s        = 1'b1;
          grant_s[idx_s] = 1'b1;
          gnt_id_s       = IDW'(idx_s);
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  assign accept_s   = found_s;
  assign sel_x_s    = bus.req_x[int'(gnt_id_s)*W +: W];
  assign sel_k_s    = bus.req_k[int'(gnt_id_s)*KW +: KW];
  assign bad_x_s    = (sel_x_s >= W'(MOD));
  assign rsp_fire_s = (state_r == DONE) && rsp_valid_r && bus.rsp_ready;

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (bad_x_s || (sel_k_s == KW'(0))) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == KW'(1)) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (rsp_fire_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, job registers and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      cnt_r       <= '0;
      id_r        <= '0;
      err_r       <= 1'b0;
      rr_ptr_r    <= '0;
      rsp_valid_r <= 1'b0;
      rsp_y_r     <= '0;
      rsp_id_r    <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            id_r  <= gnt_id_s;
            cnt_r <= sel_k_s;
            acc_r <= bad_x_s ? residue_t'(6'd0) : residue_t'(sel_x_s);
            err_r <= bad_x_s;
          end
        end
        RUN: begin
          acc_r <= lut_y_s;
          cnt_r <= cnt_r - KW'(1);
        end
        // First DONE cycle publishes the result; it then holds until taken.
        DONE: begin
          if (!rsp_valid_r) begin
            rsp_valid_r <= 1'b1;
            rsp_y_r     <= W'(acc_r);
            rsp_id_r    <= id_r;
            rsp_err_r   <= err_r;
          end else if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rr_ptr_r    <= (id_r == IDW'(NREQ - 1)) ? IDW'(0) : id_r + IDW'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_y     = rsp_y_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_err   = rsp_err_r;

`ifdef MOD47_SCALE_SCHED_STATS_EN
  logic [15:0] op_count_r;

  // Saturating count of response handshakes, errors included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_r <= 16'd0;
    end else if (rsp_fire_s && (op_count_r != 16'hFFFF)) begin
      op_count_r <= op_count_r + 16'd1;
    end
  end

  assign op_count = op_count_r;
`endif

endmodule
